// File: rtl/csr_regs_if.sv
// CSR port bundle: ex-stage read/write port, CLINT write port, and the values exported back to CLINT.
// Write ports are fire-and-forget: a *_we_i high at a rising edge commits that cycle, there is no ready/stall.
interface csr_regs_if #(parameter int XLEN = 64);
  logic            ex_we_i;
  logic [XLEN-1:0] ex_waddr_i;
  logic [XLEN-1:0] ex_wdata_i;
  logic [XLEN-1:0] ex_raddr_i;
  logic [XLEN-1:0] ex_rdata_o;
  logic            clint_we_i;
  logic [XLEN-1:0] clint_waddr_i;
  logic [XLEN-1:0] clint_data_i;
  logic [XLEN-1:0] csr_mtvec;
  logic [XLEN-1:0] csr_mepc;
  logic [XLEN-1:0] csr_mstatus;
  logic            global_int_en_o;
  logic            timer_int_o;

  modport master (
    output ex_we_i, ex_waddr_i, ex_wdata_i, ex_raddr_i,
    output clint_we_i, clint_waddr_i, clint_data_i,
    input  ex_rdata_o, csr_mtvec, csr_mepc, csr_mstatus, global_int_en_o, timer_int_o
  );

  modport slave (
    input  ex_we_i, ex_waddr_i, ex_wdata_i, ex_raddr_i,
    input  clint_we_i, clint_waddr_i, clint_data_i,
    output ex_rdata_o, csr_mtvec, csr_mepc, csr_mstatus, global_int_en_o, timer_int_o
  );
endinterface

// File: rtl/csr_regs.sv
// Machine-mode CSR register file shared by the ex stage and the CLINT.
// Port 1 (CLINT) is applied after port 0 (ex), so CLINT wins same-address conflicts.
module csr_regs #(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] MCYCLE_RST = '0
) (
  input logic      clk,
  input logic      rst,
  csr_regs_if.slave bus
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MTIMECMP = 12'h7C0;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;

  logic [XLEN-1:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mcycle_q, mtimecmp_q;
  logic [XLEN-1:0] mstatus_d, mie_d, mtvec_d, mscratch_d, mepc_d, mcause_d, mcycle_d, mtimecmp_d;
  logic            mcycle_wr;
  logic            mtip;
  logic [XLEN-1:0] mip;
  logic [XLEN-1:0] rdata;

  logic            wr_en   [2];
  logic [11:0]     wr_addr [2];
  logic [XLEN-1:0] wr_data [2];
  logic [11:0]     rd_addr;
  logic            unused_addr_bits;

  assign wr_en[0]   = bus.ex_we_i;
  assign wr_addr[0] = bus.ex_waddr_i[11:0];
  assign wr_data[0] = bus.ex_wdata_i;
  assign wr_en[1]   = bus.clint_we_i;
  assign wr_addr[1] = bus.clint_waddr_i[11:0];
  assign wr_data[1] = bus.clint_data_i;
  assign rd_addr    = bus.ex_raddr_i[11:0];

  assign unused_addr_bits = ^{bus.ex_waddr_i[XLEN-1:12], bus.clint_waddr_i[XLEN-1:12],
                              bus.ex_raddr_i[XLEN-1:12]};

  // mip is not storage: MTIP is recomputed from the registered counter and compare value.
  assign mtip = (mcycle_q >= mtimecmp_q);
  assign mip  = XLEN'(mtip) << 7;

  // Next-state values double as the forwarding source for same-cycle reads.
  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtimecmp_d = mtimecmp_q;
    mcycle_d   = mcycle_q + XLEN'(1);
    mcycle_wr  = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (wr_en[p]) begin
        case (wr_addr[p])
          A_MSTATUS:  mstatus_d  = wr_data[p];
          A_MIE:      mie_d      = wr_data[p];
          A_MTVEC:    mtvec_d    = wr_data[p];
          A_MSCRATCH: mscratch_d = wr_data[p];
          A_MEPC:     mepc_d     = wr_data[p];
          A_MCAUSE:   mcause_d   = wr_data[p];
          A_MTIMECMP: mtimecmp_d = wr_data[p];
          A_MCYCLE: begin
            mcycle_d  = wr_data[p];
            mcycle_wr = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (rd_addr)
      A_MSTATUS:  rdata = mstatus_d;
      A_MIE:      rdata = mie_d;
      A_MTVEC:    rdata = mtvec_d;
      A_MSCRATCH: rdata = mscratch_d;
      A_MEPC:     rdata = mepc_d;
      A_MCAUSE:   rdata = mcause_d;
      A_MIP:      rdata = mip;
      A_MTIMECMP: rdata = mtimecmp_d;
      A_MCYCLE:   rdata = mcycle_wr ? mcycle_d : mcycle_q;
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= MCYCLE_RST;
      mtimecmp_q <= '1;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      mtimecmp_q <= mtimecmp_d;
    end
  end

  assign bus.ex_rdata_o      = rdata;
  assign bus.csr_mtvec       = mtvec_q;
  assign bus.csr_mepc        = mepc_q;
  assign bus.csr_mstatus     = mstatus_q;
  assign bus.global_int_en_o = mstatus_q[3];
  assign bus.timer_int_o     = mstatus_q[3] & mie_q[7] & mip[7];

endmodule

// File: tb/tb_csr_regs.sv
// Self-checking bench for csr_regs: directed CSR traffic, expected values queued at drive time
// and popped when the corresponding DUT output is sampled.
module tb_csr_regs;

  logic clk;
  logic rst;

  csr_regs_if #(.XLEN(64)) bus ();

  csr_regs #(.XLEN(64), .MCYCLE_RST(64'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [63:0] exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [63:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic sb_pop_check(input logic [63:0] got);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_underflow: got %h expected nothing queued", got);
    end else begin
      check_eq(tag_q.pop_front(), got, exp_q.pop_front());
    end
  endtask

  // Driver tasks
  task automatic idle();
    bus.ex_we_i       = 1'b0;
    bus.ex_waddr_i    = '0;
    bus.ex_wdata_i    = '0;
    bus.clint_we_i    = 1'b0;
    bus.clint_waddr_i = '0;
    bus.clint_data_i  = '0;
  endtask

  task automatic ex_write(input logic [63:0] a, input logic [63:0] d);
    bus.ex_we_i    = 1'b1;
    bus.ex_waddr_i = a;
    bus.ex_wdata_i = d;
  endtask

  task automatic clint_write(input logic [63:0] a, input logic [63:0] d);
    bus.clint_we_i    = 1'b1;
    bus.clint_waddr_i = a;
    bus.clint_data_i  = d;
  endtask

  task automatic set_raddr(input logic [63:0] a);
    bus.ex_raddr_i = a;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_read(input string tag, input logic [63:0] a, input logic [63:0] v);
    set_raddr(a);
    sb_push(tag, v);
    sb_pop_check(bus.ex_rdata_o);
  endtask

  logic [63:0] mc;

  initial begin
    rst = 1'b1;
    idle();
    bus.ex_raddr_i = '0;

    // 1. reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb_push("rst_mtvec", 64'd0);   sb_pop_check(bus.csr_mtvec);
    sb_push("rst_mepc", 64'd0);    sb_pop_check(bus.csr_mepc);
    sb_push("rst_mstatus", 64'd0); sb_pop_check(bus.csr_mstatus);
    sb_push("rst_gie", 64'd0);     sb_pop_check({63'd0, bus.global_int_en_o});
    sb_push("rst_timer", 64'd0);   sb_pop_check({63'd0, bus.timer_int_o});
    expect_read("rst_mcycle", 64'hB00, 64'd0);
    expect_read("rst_mtimecmp", 64'h7C0, '1);
    expect_read("rst_mip", 64'h344, 64'd0);

    // 2. CLINT write sequence
    clint_write(64'h341, 64'h8000_0010);
    sb_push("clint_mepc", 64'h8000_0010);
    tick();
    sb_pop_check(bus.csr_mepc);
    clint_write(64'h300, 64'h0);
    tick();
    clint_write(64'h342, 64'd11);
    tick();
    idle();
    expect_read("clint_mcause", 64'h342, 64'd11);
    sb_push("clint_mstatus", 64'd0); sb_pop_check(bus.csr_mstatus);

    // 3. same-address conflict: CLINT wins
    ex_write(64'h300, 64'h8);
    clint_write(64'h300, 64'h80);
    expect_read("conflict_fwd", 64'h300, 64'h80);
    tick();
    idle();
    sb_push("conflict_mstatus", 64'h80); sb_pop_check(bus.csr_mstatus);
    sb_push("conflict_gie", 64'd0);      sb_pop_check({63'd0, bus.global_int_en_o});

    // 4. mcycle load and wrap
    ex_write(64'hB00, 64'hFFFF_FFFF_FFFF_FFFE);
    expect_read("mcycle_fwd", 64'hB00, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    idle();
    expect_read("mcycle_fe", 64'hB00, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    expect_read("mcycle_ff", 64'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    expect_read("mcycle_wrap", 64'hB00, 64'd0);

    // 5. timer interrupt; different-address writes on both ports in one cycle
    ex_write(64'h300, 64'h8);
    clint_write(64'h304, 64'h80);
    tick();
    idle();
    sb_push("tmr_gie", 64'd1);         sb_pop_check({63'd0, bus.global_int_en_o});
    sb_push("tmr_mstatus", 64'h8);     sb_pop_check(bus.csr_mstatus);
    expect_read("tmr_mie", 64'h304, 64'h80);
    ex_write(64'hB00, 64'd100);
    clint_write(64'h7C0, 64'd105);
    tick();
    idle();
    mc = 64'd100;
    for (int i = 0; i < 8; i++) begin
      expect_read("tmr_mcycle", 64'hB00, mc);
      sb_push("tmr_irq", {63'd0, (mc >= 64'd105)});
      sb_pop_check({63'd0, bus.timer_int_o});
      expect_read("tmr_mip", 64'h344, (mc >= 64'd105) ? 64'h80 : 64'h0);
      tick();
      mc = mc + 64'd1;
    end
    ex_write(64'h7C0, '1);
    sb_push("tmr_irq_still_high", 64'd1); sb_pop_check({63'd0, bus.timer_int_o});
    tick();
    idle();
    sb_push("tmr_irq_drop", 64'd0); sb_pop_check({63'd0, bus.timer_int_o});

    // 6. forwarding, mip read-only, unmapped address
    ex_write(64'h340, 64'h1234);
    expect_read("fwd_mscratch", 64'h340, 64'h1234);
    tick();
    idle();
    expect_read("mscratch_held", 64'h340, 64'h1234);
    ex_write(64'h7FF, 64'hDEAD);
    expect_read("unmapped_fwd", 64'h7FF, 64'd0);
    tick();
    idle();
    expect_read("unmapped_read", 64'h7FF, 64'd0);
    clint_write(64'h344, 64'hFFFF);
    expect_read("mip_fwd", 64'h344, 64'd0);
    tick();
    idle();
    expect_read("mip_ro", 64'h344, 64'd0);

    // 7. upper address bits ignored
    clint_write(64'hABC0_0000_0000_0305, 64'h100);
    tick();
    idle();
    sb_push("hi_addr_mtvec", 64'h100); sb_pop_check(bus.csr_mtvec);
    expect_read("hi_addr_read", 64'hFFFF_0000_0000_0305, 64'h100);

    // 8. reset overrides a concurrent write
    for (int k = 0; k < 3; k++) tick();
    ex_write(64'h341, 64'h5);
    clint_write(64'h340, 64'h77);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    sb_push("rst2_mepc", 64'd0);    sb_pop_check(bus.csr_mepc);
    sb_push("rst2_mtvec", 64'd0);   sb_pop_check(bus.csr_mtvec);
    sb_push("rst2_mstatus", 64'd0); sb_pop_check(bus.csr_mstatus);
    expect_read("rst2_mcycle", 64'hB00, 64'd0);
    expect_read("rst2_mscratch", 64'h340, 64'd0);
    expect_read("rst2_mtimecmp", 64'h7C0, '1);
    tick();
    expect_read("rst2_mcycle_run", 64'hB00, 64'd1);

    // Final report
    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
